// File: rtl/fnd_scan_ctrl_pkg.sv
// Shared types and helpers for the FND scan controller.
// Optional decimal point output is enabled with FND_SCAN_DP_EN.
package fnd_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    typedef logic [3:0] nib_t;

    localparam int MAX_DIGITS = 8;

    localparam logic [MAX_DIGITS-1:0] SEL_OFF = '1;

    function automatic logic [MAX_DIGITS-1:0] sel_onecold(
        input logic [2:0] idx
    );
        sel_onecold = ~(MAX_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/fnd_scan_timer.sv
// Slot timer: divides the clock into digit slots and rotates the index.
// Exposes the next index so the top can register aligned outputs.
module fnd_scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD_CYC  = 16
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    output logic [$clog2(NUM_DIGITS)-1:0] o_Idx_Nxt,
    output logic                          o_Wrap,
    output logic                          o_Guard_Done
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [DIV_W-1:0] r_Div;
    logic [IDX_W-1:0] r_Idx;

    assign o_Wrap       = (r_Div == DIV_W'(SCAN_DIV - 1));
    assign o_Guard_Done = (r_Div == DIV_W'(GUARD_CYC - 1));

    always_comb begin
        o_Idx_Nxt = r_Idx;
        if (o_Wrap) begin
            if (r_Idx == IDX_W'(NUM_DIGITS - 1))
                o_Idx_Nxt = '0;
            else
                o_Idx_Nxt = r_Idx + IDX_W'(1);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Div <= '0;
            r_Idx <= '0;
        end else begin
            r_Div <= o_Wrap ? '0 : r_Div + DIV_W'(1);
            r_Idx <= o_Idx_Nxt;
        end
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// UART byte buffer and multiplexed digit scan feeding the hex decoder.
// Define FND_SCAN_DP_EN to add the o_Dp decimal point output.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD_CYC  = 16
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [7:0]            i_Data,
    input  logic                  i_Valid,
    input  logic                  i_Clear,
    output logic [3:0]            o_Digit_Data,
    output logic [NUM_DIGITS-1:0] o_Digit_Sel
`ifdef FND_SCAN_DP_EN
    ,
    output logic                  o_Dp
`endif
);

    localparam int IDX_W    = $clog2(NUM_DIGITS);
    localparam int FILL_MAX = NUM_DIGITS / 2;
    localparam int FILL_W   = $clog2(FILL_MAX + 1);

    localparam logic [NUM_DIGITS-1:0] SEL_OFF_N =
        SEL_OFF[NUM_DIGITS-1:0];

    logic [IDX_W-1:0]      idx_nxt;
    logic                  wrap;
    logic                  guard_done;
    scan_state_t           state_q;
    scan_state_t           state_d;
    nib_t                  r_Nib [NUM_DIGITS];
    logic [FILL_W-1:0]     r_Fill;
    logic [MAX_DIGITS-1:0] sel_oc;
    logic                  lit;
    logic [NUM_DIGITS-1:0] sel_d;
    nib_t                  data_d;

    fnd_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .GUARD_CYC  (GUARD_CYC)
    ) u_timer (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .o_Idx_Nxt    (idx_nxt),
        .o_Wrap       (wrap),
        .o_Guard_Done (guard_done)
    );

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            state_q <= GUARD;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GUARD: if (guard_done) state_d = SHOW;
            SHOW:  if (wrap)       state_d = GUARD;
            default: state_d = GUARD;
        endcase
    end

    // Outputs are built from the next slot state so the registered
    // select lines up exactly with the guard/show phase of r_Div.
    assign sel_oc = sel_onecold(3'(idx_nxt));
    assign lit    = int'(idx_nxt) < 2 * int'(r_Fill);

    always_comb begin
        sel_d  = SEL_OFF_N;
        data_d = r_Nib[idx_nxt];
        if (state_d == SHOW && lit)
            sel_d = sel_oc[NUM_DIGITS-1:0];
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Digit_Sel  <= SEL_OFF_N;
            o_Digit_Data <= '0;
        end else begin
            o_Digit_Sel  <= sel_d;
            o_Digit_Data <= data_d;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                r_Nib[i] <= '0;
            r_Fill <= '0;
        end else if (i_Clear) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                r_Nib[i] <= '0;
            r_Fill <= '0;
        end else if (i_Valid) begin
            for (int i = NUM_DIGITS - 1; i >= 2; i--)
                r_Nib[i] <= r_Nib[i-2];
            r_Nib[1] <= i_Data[7:4];
            r_Nib[0] <= i_Data[3:0];
            if (r_Fill != FILL_W'(FILL_MAX))
                r_Fill <= r_Fill + FILL_W'(1);
        end
    end

`ifdef FND_SCAN_DP_EN
    localparam int DP_WIN = SCAN_DIV * NUM_DIGITS * 8;
    localparam int DP_W   = $clog2(DP_WIN + 1);

    logic [DP_W-1:0] r_Dp_Cnt;
    logic            dp_d;

    // Window restarts on every accepted byte; a clear also ends it.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            r_Dp_Cnt <= '0;
        else if (i_Clear)
            r_Dp_Cnt <= '0;
        else if (i_Valid)
            r_Dp_Cnt <= DP_W'(DP_WIN);
        else if (r_Dp_Cnt != '0)
            r_Dp_Cnt <= r_Dp_Cnt - DP_W'(1);
    end

    assign dp_d = !(state_d == SHOW && idx_nxt == IDX_W'(1) &&
                    r_Dp_Cnt != '0);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            o_Dp <= 1'b1;
        else
            o_Dp <= dp_d;
    end
`endif

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: cycle model feeds an expectation queue
// that is drained against the registered DUT outputs each clock.
module tb_fnd_scan_ctrl;

    localparam int N = 4;
    localparam int S = 8;
    localparam int G = 2;
    localparam int W = S * N * 8;

    logic         clk;
    logic         rst;
    logic [7:0]   data;
    logic         valid;
    logic         clear;
    logic [3:0]   dig_data;
    logic [N-1:0] dig_sel;
    logic         dp;

    fnd_scan_ctrl #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (S),
        .GUARD_CYC  (G)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Data       (data),
        .i_Valid      (valid),
        .i_Clear      (clear),
        .o_Digit_Data (dig_data),
        .o_Digit_Sel  (dig_sel)
`ifdef FND_SCAN_DP_EN
        ,
        .o_Dp         (dp)
`endif
    );

`ifndef FND_SCAN_DP_EN
    assign dp = 1'b1;
`endif

    typedef struct packed {
        logic [N-1:0] sel;
        logic [3:0]   dat;
        logic         dp;
    } exp_t;

    exp_t q[$];

    int errs   = 0;
    int checks = 0;

    int         m_div;
    int         m_idx;
    int         m_fill;
    int         m_dpc;
    logic [3:0] m_nib [N];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_div  = 0;
        m_idx  = 0;
        m_fill = 0;
        m_dpc  = 0;
        for (int i = 0; i < N; i++) m_nib[i] = 4'h0;
    endtask

    // One clock: predict, push, advance the model, then compare.
    task automatic tick(input string tag);
        int   dn;
        int   in_;
        exp_t e;
        exp_t g;
        dn  = (m_div == S - 1) ? 0 : m_div + 1;
        in_ = (m_div == S - 1) ? (m_idx + 1) % N : m_idx;
        e.sel = '1;
        if (dn >= G && in_ < 2 * m_fill) e.sel[in_] = 1'b0;
        e.dat = m_nib[in_];
`ifdef FND_SCAN_DP_EN
        e.dp = !(dn >= G && in_ == 1 && m_dpc != 0);
`else
        e.dp = 1'b1;
`endif
        q.push_back(e);
        if (clear) begin
            for (int i = 0; i < N; i++) m_nib[i] = 4'h0;
            m_fill = 0;
            m_dpc  = 0;
        end else if (valid) begin
            for (int i = N - 1; i >= 2; i--) m_nib[i] = m_nib[i-2];
            m_nib[1] = data[7:4];
            m_nib[0] = data[3:0];
            if (m_fill < N / 2) m_fill++;
            m_dpc = W;
        end else if (m_dpc > 0) begin
            m_dpc--;
        end
        m_div = dn;
        m_idx = in_;
        @(posedge clk);
        #1;
        g = q.pop_front();
        chk({tag, ".sel"}, 32'(dig_sel), 32'(g.sel));
        chk({tag, ".data"}, 32'(dig_data), 32'(g.dat));
        chk({tag, ".dp"}, 32'(dp), 32'(g.dp));
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        data  = b;
        valid = 1'b1;
        tick(tag);
        valid = 1'b0;
        data  = 8'h00;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    int ones;
    int lights;
    logic [N-1:0] prev;

    initial begin
        clk   = 1'b0;
        rst   = 1'b1;
        data  = 8'h00;
        valid = 1'b0;
        clear = 1'b0;
        model_reset();
        #1;
        chk("rst.sel", 32'(dig_sel), 32'hF);
        chk("rst.data", 32'(dig_data), 32'h0);
        chk("rst.dp", 32'(dp), 32'h1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        idle(64, "idle");

        send(8'hA5, "a5");
        idle(64, "a5");

        send(8'h12, "b3");
        send(8'h34, "b3");
        send(8'h56, "b3");
        chk("b3.nib3", 32'(m_nib[3]), 32'h3);
        while (m_div != S - 1) tick("b3");

        // Slot-aligned window: every slot opens with G blanked clocks.
        ones   = 0;
        lights = 0;
        prev   = '1;
        for (int i = 0; i < S * N; i++) begin
            tick("guard");
            if (dig_sel == '1) ones++;
            if (prev == '1 && dig_sel != '1) lights++;
            prev = dig_sel;
        end
        chk("guard.ones", 32'(ones), 32'(G * N));
        chk("guard.slots", 32'(lights), 32'(N));

        send(8'h12, "clr");
        send(8'h34, "clr");
        data  = 8'hFF;
        valid = 1'b1;
        clear = 1'b1;
        tick("clr");
        valid = 1'b0;
        clear = 1'b0;
        data  = 8'h00;
        ones = 0;
        for (int i = 0; i < S * N; i++) begin
            tick("clr");
            if (dig_sel == '1) ones++;
        end
        chk("clr.blank", 32'(ones), 32'(S * N));

        send(8'h12, "rst2");
        send(8'h34, "rst2");
        while (!(m_idx == 2 && m_div == 4)) tick("rst2");
        chk("rst2.lit", 32'(dig_sel), 32'b1011);
        #1;
        rst = 1'b1;
        #1;
        chk("rst2.sel", 32'(dig_sel), 32'hF);
        chk("rst2.dp", 32'(dp), 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(8, "rst2");
        send(8'h9C, "rst2");
        idle(40, "rst2");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
Upstream feeder for the 7-segment hex decoder in the UART display path. Accepts received UART bytes and holds them as hex nibbles in a NUM_DIGITS-deep display buffer. Time-multiplexes one nibble per scan slot onto the decoder input and drives the matching active-low digit select. Each slot starts with a blanking guard interval to suppress ghosting.

Parameters:
NUM_DIGITS, 4, number of FND digits; even, 2..8.
SCAN_DIV, 50000, clocks per digit slot; must be greater than GUARD_CYC.
GUARD_CYC, 16, clocks at the start of each slot with all selects off; must be at least 1.

Ports:
i_Clk  in  1  system clock.
i_Rst  in  1  reset; asynchronous, active-high.
i_Data  in  8  received byte.
i_Valid  in  1  single-cycle strobe; qualifies i_Data.
i_Clear  in  1  synchronous clear of buffer and fill count.
o_Digit_Data  out  4  nibble to the hex decoder; registered.
o_Digit_Sel  out  NUM_DIGITS  active-low one-cold digit enable; bit 0 is the rightmost digit.

Behaviour:
- Reset values (asynchronous): all buffer nibbles 0, fill 0, r_Idx 0, r_Div 0, state GUARD.
  - Outputs at reset: o_Digit_Data 4'h0, o_Digit_Sel all ones.
- Buffer update on i_Valid, with i_Clear low:
  - Shift left by two nibbles; the oldest pair is discarded.
  - nib[1] <= i_Data[7:4], nib[0] <= i_Data[3:0].
  - Fill (bytes held) increments and saturates at NUM_DIGITS/2.
- Buffer update on i_Clear:
  - Nibbles and fill go to 0.
  - Same cycle as i_Valid: clear wins and the byte is dropped.
- Handshake: always ready, no backpressure. Valid strobes on back-to-back cycles are each accepted.
- Scan timer:
  - r_Div counts 0..SCAN_DIV-1 and wraps.
  - At the wrap, r_Idx increments modulo NUM_DIGITS (NUM_DIGITS-1 goes to 0).
- State machine with two states:
  - GUARD while r_Div < GUARD_CYC; SHOW otherwise.
  - Transitions are GUARD->SHOW at r_Div == GUARD_CYC and SHOW->GUARD at the wrap.
- Outputs in GUARD: o_Digit_Sel all ones; o_Digit_Data <= nib[r_Idx] (loaded for the new slot).
- Outputs in SHOW:
  - o_Digit_Sel has bit r_Idx low when r_Idx < 2*fill; otherwise all ones (digit blanked).
  - o_Digit_Data tracks nib[r_Idx] with one register stage.
- Latency: i_Valid at edge n updates the buffer at edge n+1. o_Digit_Data reflects it at edge n+2 if that digit is being scanned.
- A buffer write mid-SHOW changes the shown digit immediately (no slot restart).
- Reset asserted mid-slot returns to GUARD with r_Idx 0 and no select glitch low. Outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
Macro FND_SCAN_DP_EN.
- Defined:
  - Adds output o_Dp (1 bit, active-low decimal point).
  - o_Dp is low during SHOW on digit 1 (the high nibble of the newest byte) for SCAN_DIV*NUM_DIGITS*8 clocks after each accepted i_Valid; each new byte restarts that window.
  - o_Dp is high in GUARD and at reset.
- Undefined: no o_Dp port and no related logic. All other behaviour is identical.

Decomposition:
- Package fnd_pkg holds:
  - the scan state enum {GUARD, SHOW};
  - the localparam SEL_OFF (all-ones select);
  - the nibble type (4-bit);
  - a function that computes the active-low one-cold select from an index.
- Sub-module fnd_scan_timer holds r_Div and r_Idx and emits a slot-wrap pulse and a guard flag. The top keeps the buffer, fill and output registers.
- The hex-to-segment decoder is instantiated outside, at the top level.

Test Plan:
1. Reset and idle (NUM_DIGITS=4, SCAN_DIV=8, GUARD_CYC=2), no input for 64 clocks -> o_Digit_Sel stays 4'b1111 (fill 0) and o_Digit_Data stays 4'h0.
2. Single byte 0xA5 -> in slot 0, SHOW cycles 2..7 show Sel 4'b1110 with Data 4'h5; in slot 1 they show Sel 4'b1101 with Data 4'hA; slots 2 and 3 stay at Sel 4'b1111.
3. Bytes 0x12, 0x34, 0x56 back-to-back -> buffer digits 3..0 read 3,4,5,6; 0x12 is discarded; all four digits light in rotation 6,5,4,3.
4. Guard check -> on every slot wrap, Sel is 4'b1111 for exactly 2 clocks before any bit goes low; r_Idx wraps from 3 to 0.
5. i_Clear and i_Valid (0xFF) in the same cycle with buffer 0x1234 -> buffer 0x0000, fill 0, all digits blank.
6. Reset pulse mid-SHOW on digit 2 -> Sel goes to 4'b1111 asynchronously and scan restarts at digit 0 in GUARD. With FND_SCAN_DP_EN, o_Dp is high after reset and goes low on digit 1 after the next byte.
